// File: rtl/risci_pkg.sv
// Shared register-file writeback types: size encodings and the writeback payload.
package risci_pkg;

  localparam int unsigned RISCI_XLEN = 64;
  localparam int unsigned RISCI_XWDT = 6;
  localparam int unsigned RISCI_XN   = 64;
  localparam int unsigned RISCI_PA   = 3;
  localparam int unsigned RISCI_NREQ = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef struct packed {
    logic [RISCI_XWDT-1:0] idx;
    logic [RISCI_XLEN-1:0] data;
    logic [1:0]            size;
    logic [2:0]            pos;
  } wb_req_t;

endpackage

// File: rtl/rr_multigrant.sv
// Combinational round-robin scan granting up to PA requesters per cycle,
// skipping any requester whose index collides with an earlier grant.
module rr_multigrant #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned PA   = 3,
  parameter  int unsigned XWDT = 6,
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CNTW = $clog2(PA + 1)
) (
  input  logic [NREQ-1:0]           valid,
  input  logic [NREQ-1:0][XWDT-1:0] idx,
  input  logic [SELW-1:0]           ptr,
  output logic [NREQ-1:0]           grant_c,
  output logic [PA-1:0][SELW-1:0]   sel_c,
  output logic [CNTW-1:0]           ngrant_c,
  output logic [SELW-1:0]           next_ptr_c
);

  logic [SELW-1:0] j;
  logic            clash;

  always_comb begin
    grant_c    = '0;
    sel_c      = '0;
    ngrant_c   = '0;
    next_ptr_c = ptr;
    j          = '0;
    clash      = 1'b0;
    for (int unsigned o = 0; o < NREQ; o++) begin
      j     = SELW'((32'(ptr) + o) % NREQ);
      clash = 1'b0;
      for (int unsigned m = 0; m < NREQ; m++) begin
        if (grant_c[m] && (idx[m] == idx[j])) clash = 1'b1;
      end
      if (valid[j] && (ngrant_c < CNTW'(PA)) && !clash) begin
        grant_c[j]      = 1'b1;
        sel_c[ngrant_c] = j;
        ngrant_c        = ngrant_c + CNTW'(1);
        next_ptr_c      = SELW'((32'(j) + 32'd1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin multi-grant, one registered
// output stage onto the write ports, and a per-register busy scoreboard.
module rf_wb_arbiter
  import risci_pkg::*;
#(
  parameter int unsigned XLEN           = RISCI_XLEN,
  parameter int unsigned XWDT           = RISCI_XWDT,
  parameter int unsigned XN             = RISCI_XN,
  parameter int unsigned PARALLELACCESS = RISCI_PA,
  parameter int unsigned NREQ           = RISCI_NREQ
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ-1:0][XWDT-1:0]            req_idx,
  input  logic [NREQ-1:0][XLEN-1:0]            req_data,
  input  logic [NREQ-1:0][1:0]                 req_size,
  input  logic [NREQ-1:0][2:0]                 req_pos,
  output logic [PARALLELACCESS-1:0][XWDT-1:0]  rwrites,
  output logic [PARALLELACCESS-1:0][XLEN-1:0]  rins,
  output logic [PARALLELACCESS-1:0][1:0]       rwsizes,
  output logic [PARALLELACCESS-1:0][2:0]       rwposs,
  output logic                                 we,
  input  logic                                 sb_set,
  input  logic [XWDT-1:0]                      sb_set_idx,
  input  logic [PARALLELACCESS-1:0][XWDT-1:0]  sb_chk_idx,
  output logic [PARALLELACCESS-1:0]            sb_busy
);

  localparam int unsigned PA   = PARALLELACCESS;
  localparam int unsigned SELW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW = $clog2(PA + 1);

  logic [SELW-1:0]         ptr;
  logic [NREQ-1:0]         grant_c;
  logic [PA-1:0][SELW-1:0] sel_c;
  logic [CNTW-1:0]         ngrant_c;
  logic [SELW-1:0]         next_ptr_c;
  wb_req_t                 req_pl [NREQ];
  wb_req_t                 port_q [PA];
  logic [XN-1:0]           board;
  logic [XN-1:0]           board_n;

  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      req_pl[r].idx  = req_idx[r];
      req_pl[r].data = req_data[r];
      req_pl[r].size = req_size[r];
      req_pl[r].pos  = req_pos[r];
    end
  end

  rr_multigrant #(
    .NREQ (NREQ),
    .PA   (PA),
    .XWDT (XWDT)
  ) u_scan (
    .valid      (req_valid),
    .idx        (req_idx),
    .ptr        (ptr),
    .grant_c    (grant_c),
    .sel_c      (sel_c),
    .ngrant_c   (ngrant_c),
    .next_ptr_c (next_ptr_c)
  );

  assign req_ready = rst ? '0 : grant_c;

  // Clears from the write currently at the register file, then the issue set (set wins).
  always_comb begin
    board_n = board;
    if (we) begin
      for (int unsigned k = 0; k < PA; k++) board_n[port_q[k].idx] = 1'b0;
    end
    if (sb_set && (sb_set_idx != '0)) board_n[sb_set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      we    <= 1'b0;
      board <= '0;
      for (int unsigned k = 0; k < PA; k++) port_q[k] <= '0;
    end else begin
      ptr   <= next_ptr_c;
      we    <= (ngrant_c != '0);
      board <= board_n;
      // Ungranted ports mirror port 0 so the shared enable writes duplicates only.
      if (ngrant_c != '0) begin
        for (int unsigned k = 0; k < PA; k++) begin
          port_q[k] <= req_pl[(CNTW'(k) < ngrant_c) ? sel_c[k] : sel_c[0]];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < PA; k++) begin
      rwrites[k] = port_q[k].idx;
      rins[k]    = port_q[k].data;
      rwsizes[k] = port_q[k].size;
      rwposs[k]  = port_q[k].pos;
      sb_busy[k] = board[sb_chk_idx[k]];
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, scoreboard sequences and
// random traffic, all checked against a transaction-level reference model.
module tb_rf_wb_arbiter;
  import risci_pkg::*;

  localparam int NR = 4;
  localparam int PA = 3;
  localparam int XN = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][5:0]    req_idx;
  logic [NR-1:0][63:0]   req_data;
  logic [NR-1:0][1:0]    req_size;
  logic [NR-1:0][2:0]    req_pos;
  logic [PA-1:0][5:0]    rwrites;
  logic [PA-1:0][63:0]   rins;
  logic [PA-1:0][1:0]    rwsizes;
  logic [PA-1:0][2:0]    rwposs;
  logic                  we;
  logic                  sb_set;
  logic [5:0]            sb_set_idx;
  logic [PA-1:0][5:0]    sb_chk_idx;
  logic [PA-1:0]         sb_busy;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_idx    (req_idx),
    .req_data   (req_data),
    .req_size   (req_size),
    .req_pos    (req_pos),
    .rwrites    (rwrites),
    .rins       (rins),
    .rwsizes    (rwsizes),
    .rwposs     (rwposs),
    .we         (we),
    .sb_set     (sb_set),
    .sb_set_idx (sb_set_idx),
    .sb_chk_idx (sb_chk_idx),
    .sb_busy    (sb_busy)
  );

  typedef struct {
    logic [3:0]       v;
    logic [3:0][5:0]  idx;
    logic [3:0][63:0] data;
    logic [3:0][1:0]  size;
    logic [3:0][2:0]  pos;
    logic [3:0]       exp_ready;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  // reference model: pointer, busy set, and the write sitting at the register file
  int            m_ptr;
  bit            m_board [XN];
  bit            m_we;
  wb_req_t       m_port [PA];
  // requester side: pending flag and held payload
  bit            pv [NR];
  wb_req_t       pr [NR];
  logic [63:0]   regfile [XN];
  logic [NR-1:0] last_ready;
  logic [PA-1:0] last_busy;
  vec_t          vt [6];

  function automatic wb_req_t mk(input logic [5:0] i, input logic [63:0] d,
                                 input logic [1:0] s, input logic [2:0] p);
    wb_req_t r;
    r.idx  = i;
    r.data = d;
    r.size = s;
    r.pos  = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 1'b0;
    for (int i = 0; i < XN; i++) m_board[i] = 1'b0;
    for (int k = 0; k < PA; k++) m_port[k] = '0;
  endtask

  // One clock: drive, check against the model, advance model and requesters.
  task automatic cycle();
    int            gl [$];
    logic [5:0]    used [$];
    logic [NR-1:0] er;
    bit            nb [XN];
    wb_req_t       np [PA];
    int            nptr;
    bit            nwe;
    for (int j = 0; j < NR; j++) begin
      req_valid[j] = pv[j];
      req_idx[j]   = pr[j].idx;
      req_data[j]  = pr[j].data;
      req_size[j]  = pr[j].size;
      req_pos[j]   = pr[j].pos;
    end
    #1;
    for (int o = 0; o < NR; o++) begin
      int j;
      bit dup;
      j   = (m_ptr + o) % NR;
      dup = 1'b0;
      foreach (used[u]) if (used[u] == pr[j].idx) dup = 1'b1;
      if (pv[j] && gl.size() < PA && !dup) begin
        gl.push_back(j);
        used.push_back(pr[j].idx);
      end
    end
    er = '0;
    if (!rst) foreach (gl[g]) er[gl[g]] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    for (int i = 0; i < PA; i++)
      chk($sformatf("sb_busy%0d", i), 64'(sb_busy[i]), 64'(m_board[sb_chk_idx[i]]));
    chk("we", 64'(we), 64'(m_we));
    for (int k = 0; k < PA; k++) begin
      chk($sformatf("rwrites%0d", k), 64'(rwrites[k]), 64'(m_port[k].idx));
      chk($sformatf("rins%0d", k), rins[k], m_port[k].data);
      chk($sformatf("rwsz_pos%0d", k), 64'({rwsizes[k], rwposs[k]}),
          64'({m_port[k].size, m_port[k].pos}));
    end
    last_ready = req_ready;
    last_busy  = sb_busy;
    if (we === 1'b1) for (int k = 0; k < PA; k++) regfile[rwrites[k]] = rins[k];
    nb   = m_board;
    np   = m_port;
    nptr = m_ptr;
    nwe  = 1'b0;
    if (rst) begin
      for (int i = 0; i < XN; i++) nb[i] = 1'b0;
      for (int k = 0; k < PA; k++) np[k] = '0;
      nptr = 0;
    end else begin
      if (m_we) for (int k = 0; k < PA; k++) nb[m_port[k].idx] = 1'b0;
      if (sb_set && sb_set_idx != 6'd0) nb[sb_set_idx] = 1'b1;
      if (gl.size() > 0) begin
        nwe  = 1'b1;
        nptr = (gl[gl.size() - 1] + 1) % NR;
        for (int k = 0; k < PA; k++) np[k] = pr[(k < gl.size()) ? gl[k] : gl[0]];
      end
    end
    @(posedge clk);
    #1;
    m_board = nb;
    m_port  = np;
    m_ptr   = nptr;
    m_we    = nwe;
    for (int j = 0; j < NR; j++) if (last_ready[j]) pv[j] = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    sb_set     = 1'b0;
    sb_set_idx = '0;
    sb_chk_idx = '0;
    req_valid  = '0;
    req_idx    = '0;
    req_data   = '0;
    req_size   = '0;
    req_pos    = '0;
    for (int i = 0; i < XN; i++) regfile[i] = '0;
    for (int j = 0; j < NR; j++) begin
      pv[j] = 1'b1;
      pr[j] = mk(6'(j + 1), 64'(j), SZ_D, 3'd0);
    end
    model_reset();
    @(posedge clk);
    #1;

    // reset held with everyone requesting
    repeat (2) begin
      cycle();
      chk("rst_ready", 64'(last_ready), 64'd0);
      chk("rst_we", 64'(we), 64'd0);
    end
    rst = 1'b0;

    vt[0] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {64'h13, 64'h12, 64'h11, 64'h10},
              {4{SZ_D}}, '0, 4'b0111};
    vt[1] = '{4'b1111, {6'd4, 6'd7, 6'd6, 6'd5}, {64'h13, 64'h22, 64'h21, 64'h20},
              {4{SZ_D}}, '0, 4'b1011};
    vt[2] = '{4'b0011, {6'd0, 6'd0, 6'd5, 6'd5}, {64'h0, 64'h0, 64'hBB, 64'hAA},
              {4{SZ_D}}, '0, 4'b0001};
    vt[3] = '{4'b0010, {6'd0, 6'd0, 6'd5, 6'd5}, {64'h0, 64'h0, 64'hBB, 64'hAA},
              {4{SZ_D}}, '0, 4'b0010};
    vt[4] = '{4'b0100, {6'd0, 6'd7, 6'd0, 6'd0}, {64'h0, 64'h1234, 64'h0, 64'h0},
              {SZ_D, SZ_H, SZ_D, SZ_D}, {3'd0, 3'd3, 3'd0, 3'd0}, 4'b0100};
    vt[5] = '{4'b0000, '0, '0, '0, '0, 4'b0000};

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < NR; j++) begin
        pv[j] = vt[r].v[j];
        pr[j] = mk(vt[r].idx[j], vt[r].data[j], vt[r].size[j], vt[r].pos[j]);
      end
      cycle();
      chk($sformatf("vec%0d_ready", r), 64'(last_ready), 64'(vt[r].exp_ready));
      if (r == 4) begin
        chk("repl_we", 64'(we), 64'd1);
        for (int k = 0; k < PA; k++) begin
          chk($sformatf("repl_idx%0d", k), 64'(rwrites[k]), 64'd7);
          chk($sformatf("repl_data%0d", k), rins[k], 64'h1234);
          chk($sformatf("repl_size%0d", k), 64'(rwsizes[k]), 64'(SZ_H));
          chk($sformatf("repl_pos%0d", k), 64'(rwposs[k]), 64'd3);
        end
      end
    end
    cycle();
    chk("reg5_final", regfile[5], 64'hBB);

    // busy bit lifetime around a write to register 9
    sb_chk_idx = {6'd0, 6'd0, 6'd9};
    sb_set = 1'b1; sb_set_idx = 6'd9;
    cycle();
    sb_set = 1'b0;
    cycle();
    chk("sb_c1", 64'(last_busy[0]), 64'd1);
    pv[0] = 1'b1; pr[0] = mk(6'd9, 64'h99, SZ_D, 3'd0);
    cycle();
    chk("sb_c2", 64'(last_busy[0]), 64'd1);
    cycle();
    chk("sb_c3", 64'(last_busy[0]), 64'd1);
    cycle();
    chk("sb_c4", 64'(last_busy[0]), 64'd0);

    // set on the same edge as the clear keeps the bit
    sb_set = 1'b1; sb_set_idx = 6'd9;
    cycle();
    sb_set = 1'b0;
    pv[0] = 1'b1; pr[0] = mk(6'd9, 64'h9A, SZ_D, 3'd0);
    cycle();
    sb_set = 1'b1; sb_set_idx = 6'd9;
    cycle();
    sb_set = 1'b0;
    cycle();
    chk("set_wins_a", 64'(last_busy[0]), 64'd1);
    cycle();
    chk("set_wins_b", 64'(last_busy[0]), 64'd1);

    // register 0 never becomes busy
    sb_set = 1'b1; sb_set_idx = 6'd0;
    cycle();
    sb_set = 1'b0;
    cycle();
    chk("idx0_busy", 64'(last_busy[1]), 64'd0);

    // random traffic with a reset in the middle
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NR; j++) begin
        if (!pv[j] && ($urandom % 3 == 0)) begin
          pv[j] = 1'b1;
          pr[j] = mk(6'($urandom_range(0, 7)), {$urandom, $urandom},
                     2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
      end
      sb_set     = ($urandom % 4 == 0);
      sb_set_idx = 6'($urandom_range(0, 7));
      for (int i = 0; i < PA; i++) sb_chk_idx[i] = 6'($urandom_range(0, 7));
      rst = (c == 200 || c == 201);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
